// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: ALU_Control load/store codes, FSM encoding
// and access-size decode helpers used by mem_stage and mem_align.
package mem_pkg;

    localparam logic [5:0] ALU_LB  = 6'h20;
    localparam logic [5:0] ALU_LH  = 6'h21;
    localparam logic [5:0] ALU_LW  = 6'h23;
    localparam logic [5:0] ALU_LBU = 6'h24;
    localparam logic [5:0] ALU_LHU = 6'h25;
    localparam logic [5:0] ALU_SB  = 6'h28;
    localparam logic [5:0] ALU_SH  = 6'h29;
    localparam logic [5:0] ALU_SW  = 6'h2B;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

    typedef struct packed {
        mem_size_t size;
        logic      is_unsigned;
    } mem_fmt_t;

    // Codes that are not a recognised load/store fall back to a word access.
    function automatic mem_fmt_t decode_fmt(input logic [5:0] alu_ctrl);
        mem_fmt_t fmt;
        fmt.size        = SIZE_WORD;
        fmt.is_unsigned = 1'b0;
        case (alu_ctrl)
            ALU_LB, ALU_SB: fmt.size = SIZE_BYTE;
            ALU_LBU: begin
                fmt.size        = SIZE_BYTE;
                fmt.is_unsigned = 1'b1;
            end
            ALU_LH, ALU_SH: fmt.size = SIZE_HALF;
            ALU_LHU: begin
                fmt.size        = SIZE_HALF;
                fmt.is_unsigned = 1'b1;
            end
            default: fmt.size = SIZE_WORD;
        endcase
        return fmt;
    endfunction

    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] align_addr(input mem_size_t size, input logic [31:0] addr);
        logic [31:0] aligned;
        case (size)
            SIZE_HALF: aligned = {addr[31:1], 1'b0};
            SIZE_WORD: aligned = {addr[31:2], 2'b00};
            default:   aligned = addr;
        endcase
        return aligned;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables and replication, load lane select
// with sign/zero extension (little-endian).
module mem_align
    import mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic        is_unsigned,
    input  logic        is_store,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (addr_lo)
            2'd0:    lane_byte = load_word[7:0];
            2'd1:    lane_byte = load_word[15:8];
            2'd2:    lane_byte = load_word[23:16];
            default: lane_byte = load_word[31:24];
        endcase
        lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    // Loads always fetch the whole word; only stores narrow the byte enables.
    always_comb begin
        byte_en    = 4'b1111;
        store_word = store_data;
        load_data  = load_word;
        case (size)
            SIZE_BYTE: begin
                load_data = is_unsigned ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
                if (is_store) begin
                    byte_en    = 4'b0001 << addr_lo;
                    store_word = {4{store_data[7:0]}};
                end
            end
            SIZE_HALF: begin
                load_data = is_unsigned ? {16'h0, lane_half} : {{16{lane_half[15]}}, lane_half};
                if (is_store) begin
                    byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    store_word = {2{store_data[15:0]}};
                end
            end
            default: begin
                load_data = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage with a two-state data-memory handshake and optional access timeout.
// Define UNALIGNED_TRAP_EN to flag misaligned accesses instead of truncating addresses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Instr_IN,
    input  logic [31:0] Instr_PC_IN,
    input  logic [31:0] ALU_result_IN,
    input  logic [4:0]  WriteRegister_IN,
    input  logic [31:0] MemWriteData_IN,
    input  logic        RegWrite_IN,
    input  logic        MemRead_IN,
    input  logic        MemWrite_IN,
    input  logic [5:0]  ALU_Control_IN,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] Instr_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] WriteData_OUT,
    output logic [4:0]  WriteRegister_OUT,
    output logic        RegWrite_OUT,
    output logic [31:0] Fwd_EXEMEM_OUT,
    output logic        Stall_OUT,
    output logic        Misalign_OUT,
    output logic        Timeout_OUT
);

    logic [0:0]  state;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [31:0] lat_instr;
    logic [31:0] lat_pc;
    logic [4:0]  lat_wreg;
    logic        lat_regwrite;
    logic        lat_store;
    mem_fmt_t    lat_fmt;
    logic [31:0] wait_cnt;

    mem_fmt_t    in_fmt;
    logic        mem_op;
    logic        trap_in;
    logic        start_access;
    logic        timeout_hit;
    logic [31:0] load_data;

    assign in_fmt = decode_fmt(ALU_Control_IN);
    assign mem_op = MemRead_IN | MemWrite_IN;

`ifdef UNALIGNED_TRAP_EN
    assign trap_in = mem_op & is_misaligned(in_fmt.size, ALU_result_IN[1:0]);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Misalign_OUT <= 1'b0;
        end else begin
            Misalign_OUT <= (state == IDLE) & trap_in;
        end
    end
`else
    assign trap_in      = 1'b0;
    assign Misalign_OUT = 1'b0;
`endif

    assign start_access = (state == IDLE) & mem_op & ~trap_in;
    assign timeout_hit  = (DMEM_TIMEOUT > 0) && (wait_cnt == 32'(DMEM_TIMEOUT - 1));

    assign dmem_req       = (state == ACCESS);
    assign dmem_we        = dmem_req & lat_store;
    assign dmem_addr      = {lat_addr[31:2], 2'b00};
    assign Fwd_EXEMEM_OUT = ALU_result_IN;
    assign Stall_OUT      = (state == IDLE) ? start_access : ~dmem_ack;

    mem_align u_align (
        .size        (lat_fmt.size),
        .is_unsigned (lat_fmt.is_unsigned),
        .is_store    (lat_store),
        .addr_lo     (lat_addr[1:0]),
        .store_data  (lat_data),
        .load_word   (dmem_rdata),
        .byte_en     (dmem_be),
        .store_word  (dmem_wdata),
        .load_data   (load_data)
    );

    // A mem op entering from IDLE becomes a bubble; WB sees it only when the ack arrives.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state             <= IDLE;
            lat_addr          <= '0;
            lat_data          <= '0;
            lat_instr         <= '0;
            lat_pc            <= '0;
            lat_wreg          <= '0;
            lat_regwrite      <= 1'b0;
            lat_store         <= 1'b0;
            lat_fmt           <= '{size: SIZE_WORD, is_unsigned: 1'b0};
            wait_cnt          <= '0;
            Instr_OUT         <= '0;
            Instr_PC_OUT      <= '0;
            WriteData_OUT     <= '0;
            WriteRegister_OUT <= '0;
            RegWrite_OUT      <= 1'b0;
            Timeout_OUT       <= 1'b0;
        end else begin
            Timeout_OUT <= 1'b0;
            if (state == IDLE) begin
                Instr_OUT         <= Instr_IN;
                Instr_PC_OUT      <= Instr_PC_IN;
                WriteRegister_OUT <= WriteRegister_IN;
                WriteData_OUT     <= ALU_result_IN;
                RegWrite_OUT      <= RegWrite_IN & ~mem_op;
                wait_cnt          <= '0;
                if (start_access) begin
                    lat_addr     <= align_addr(in_fmt.size, ALU_result_IN);
                    lat_data     <= MemWriteData_IN;
                    lat_instr    <= Instr_IN;
                    lat_pc       <= Instr_PC_IN;
                    lat_wreg     <= WriteRegister_IN;
                    lat_regwrite <= RegWrite_IN;
                    lat_store    <= MemWrite_IN;
                    lat_fmt      <= in_fmt;
                    state        <= ACCESS;
                end
            end else if (dmem_ack) begin
                Instr_OUT         <= lat_instr;
                Instr_PC_OUT      <= lat_pc;
                WriteRegister_OUT <= lat_wreg;
                WriteData_OUT     <= lat_store ? lat_addr : load_data;
                RegWrite_OUT      <= lat_regwrite;
                state             <= IDLE;
            end else begin
                RegWrite_OUT <= 1'b0;
                if (timeout_hit) begin
                    Timeout_OUT <= 1'b1;
                    state       <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter: DMEM_TIMEOUT, default 0, meaning: 0 disables; >0 aborts an access after N ACCESS cycles without ack.
REQ-002 SHALL have ports, clock and reset first:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- Instr_IN, Instr_PC_IN  in  32  debug instruction and PC from the EXE pipeline register.
- ALU_result_IN  in  32  ALU result, or the byte address for memory operations.
- WriteRegister_IN  in  5  destination register.
- MemWriteData_IN  in  32  store data.
- RegWrite_IN, MemRead_IN, MemWrite_IN  in  1  control bits.
- ALU_Control_IN  in  6  operation code, selects load/store size.
- dmem_req, dmem_we  out  1  memory request and write enable.
- dmem_addr  out  32  word-aligned address (bits [1:0] = 0).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  access complete; read data valid this cycle.
- dmem_rdata  in  32  read word.
- Instr_OUT, Instr_PC_OUT  out  32  to WB.
- WriteData_OUT  out  32  load data or ALU result to WB.
- WriteRegister_OUT  out  5  to WB.
- RegWrite_OUT  out  1  to WB.
- Fwd_EXEMEM_OUT  out  32  combinational, equals ALU_result_IN; drives EXE forward path 01.
- Stall_OUT  out  1  combinational; upstream holds while high.
- Misalign_OUT  out  1  misaligned-access flag (see Configuration).
- Timeout_OUT  out  1  one-cycle pulse when an access is aborted by DMEM_TIMEOUT.

Function
REQ-003 SHALL implement FSM states IDLE and ACCESS.
REQ-004 IDLE with no memory operation: each posedge SHALL register the inputs to the WB outputs (WriteData_OUT = ALU_result_IN); latency is 1 cycle.
REQ-005 IDLE with MemRead_IN or MemWrite_IN high:
- Stall_OUT SHALL be high.
- Posedge SHALL latch address, data, control and debug fields, then go to ACCESS.
- RegWrite_OUT SHALL be 0 (bubble).
REQ-006 ACCESS:
- dmem_req SHALL be high; dmem_we = latched MemWrite.
- Stall_OUT SHALL equal !dmem_ack.
- Posedge without ack SHALL give a bubble (RegWrite_OUT = 0).
REQ-007 ACCESS with dmem_ack:
- Posedge SHALL register the latched fields to WB, with WriteData_OUT = formatted load data (loads) or the latched address (stores).
- FSM SHALL return to IDLE.
- Minimum memory latency is 2 cycles.
REQ-008 dmem_ack SHALL be ignored in IDLE.
REQ-009 Load formatting SHALL be little-endian, lane = addr[1:0]:
- LB: sign-extend the lane byte; LBU: zero-extend it.
- LH: sign-extend the half at addr[1]; LHU: zero-extend it.
- LW: full word.
REQ-010 Store formatting:
- SB: wdata = {4{data[7:0]}}, be = 4'b0001<<addr[1:0].
- SH: wdata = {2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
- SW: wdata = data, be = 4'b1111.
- Loads: be = 4'b1111.
REQ-011 If ALU_Control_IN is not a load/store code while MemRead_IN or MemWrite_IN is high, the access SHALL be treated as word-sized.
REQ-012 DMEM_TIMEOUT>0 and DMEM_TIMEOUT ACCESS cycles without ack:
- Access SHALL be dropped and the FSM SHALL return to IDLE.
- RegWrite_OUT SHALL be 0 and Timeout_OUT SHALL pulse 1 cycle.
REQ-013 MemRead_IN and MemWrite_IN both high SHALL be treated as a store.

Reset
REQ-014 RESET low SHALL immediately force:
- FSM to IDLE.
- All registered outputs and dmem_req to 0.
- Any in-flight access abandoned (no retry after reset).

Configuration
REQ-015 With UNALIGNED_TRAP_EN defined:
- Misaligned accesses are LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
- A misaligned access SHALL issue no request and SHALL NOT stall.
- It SHALL register Misalign_OUT = 1 for one cycle with RegWrite_OUT = 0.
REQ-016 Without UNALIGNED_TRAP_EN:
- Low address bits SHALL be truncated to the access size.
- Misalign_OUT SHALL be tied 0.

Structure
REQ-017 Shared package mem_pkg SHALL hold:
- ALU_Control codes: LB 6'h20, LH 6'h21, LW 6'h23, LBU 6'h24, LHU 6'h25, SB 6'h28, SH 6'h29, SW 6'h2B.
- FSM state encoding.
REQ-018 Sub-module mem_align SHALL be combinational and SHALL hold the byte-enable, store-replication and load-extension logic.

Verification
REQ-019 Bench SHALL cover:
- ALU op, result 0x1234 -> next posedge WriteData_OUT=0x1234, Stall_OUT never high.
- LB addr 0x103, rdata 0x80FF_0000, ack in first ACCESS cycle -> WriteData_OUT=0xFFFF_FF80, Stall_OUT high exactly 1 cycle.
- SH addr 0x102, data 0xABCD -> be=4'b1100, wdata=0xABCD_ABCD, dmem_addr=0x100.
- LW, ack delayed 3 cycles -> 3 bubbles, then result; RESET low in the 2nd wait cycle -> dmem_req=0 immediately, IDLE, outputs 0.
- UNALIGNED_TRAP_EN, LW addr 0x101 -> no dmem_req, Misalign_OUT=1 for 1 cycle, RegWrite_OUT=0.
- DMEM_TIMEOUT=4, no ack -> Timeout_OUT pulse after 4 ACCESS cycles, back to IDLE.
